// File: rtl/sine_voice_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sine_voice_scheduler_pkg
// Brief    : Shared constants and helpers for the sine voice scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sine_voice_scheduler_pkg;

    localparam int c_VOICES      = 4;
    localparam int c_PHASE_W     = 8;
    localparam int c_IDX_W       = 6;
    localparam int c_SAMPLE_W    = 16;
    localparam int c_VOICE_IDX_W = 2;

    // Per-stage pipeline occupancy encoding.
    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    // Odd quadrants run the quarter table backwards.
    function automatic logic [c_IDX_W-1:0] fold_phase(input logic [c_PHASE_W-1:0] ph);
        return ph[c_PHASE_W-2] ? ~ph[c_IDX_W-1:0] : ph[c_IDX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Masked round-robin arbiter with one-hot grant and pointer register.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_mask,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [N-1:0]     w_elig;
    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest slot to the pointer so the nearest eligible wins.
    always_comb begin
        w_elig  = i_req & ~i_mask;
        w_cand  = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = r_ptr + IDX_W'(i);
            if (w_elig[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        o_gnt = o_valid ? (N'(1) << o_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            r_ptr <= o_idx + IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sine_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sine_voice_scheduler
// Brief    : Round-robin scheduler sharing one quarter-wave sine table among voices.
// Revision : 1.0 - initial release
// ============================================================================
module sine_voice_scheduler
    import sine_voice_scheduler_pkg::*;
#(
    parameter int VOICES  = c_VOICES,
    parameter int PHASE_W = c_PHASE_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [VOICES-1:0]         req,
    input  logic [VOICES*PHASE_W-1:0] phase,
    output logic [VOICES-1:0]         grant,
    output logic [c_IDX_W-1:0]        table_phase,
    input  logic [c_SAMPLE_W-1:0]     table_data,
    output logic                      sample_valid,
    output logic [c_VOICE_IDX_W-1:0]  sample_voice,
    output logic [c_SAMPLE_W-1:0]     sample
);

    logic [VOICES-1:0]        w_req_gated;
    logic [VOICES-1:0]        w_sel_onehot;
    logic                     w_sel_valid;
    logic [c_VOICE_IDX_W-1:0] w_sel_idx;

    logic [0:0]               r_s1_state;
    logic [0:0]               r_s2_state;
    logic [0:0]               w_s1_next;
    logic [0:0]               w_s2_next;

    logic [c_VOICE_IDX_W-1:0] r_s1_voice;
    logic [c_PHASE_W-1:0]     r_s1_phase;
    logic [VOICES-1:0]        r_s1_grant;
    logic [c_VOICE_IDX_W-1:0] r_sample_voice;
    logic [c_SAMPLE_W-1:0]    r_sample;

    assign w_req_gated = reset ? '0 : req;

    // The voice currently holding grant is masked so a held request is not re-serviced.
    rr_arbiter #(
        .N     (VOICES),
        .IDX_W (c_VOICE_IDX_W)
    ) u_arb (
        .clk     (clock),
        .rst     (reset),
        .i_req   (w_req_gated),
        .i_mask  (grant),
        .o_gnt   (w_sel_onehot),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_state <= c_ST_EMPTY;
            r_s2_state <= c_ST_EMPTY;
        end else begin
            r_s1_state <= w_s1_next;
            r_s2_state <= w_s2_next;
        end
    end

    always_comb begin
        w_s1_next = w_sel_valid ? c_ST_FULL : c_ST_EMPTY;
        w_s2_next = (r_s1_state == c_ST_FULL) ? c_ST_FULL : c_ST_EMPTY;
    end

    always_comb begin
        grant        = '0;
        table_phase  = '0;
        sample_valid = (r_s2_state == c_ST_FULL);
        if (r_s1_state == c_ST_FULL) begin
            grant       = r_s1_grant;
            table_phase = fold_phase(r_s1_phase);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_voice     <= '0;
            r_s1_phase     <= '0;
            r_s1_grant     <= '0;
            r_sample_voice <= '0;
            r_sample       <= '0;
        end else begin
            if (w_sel_valid) begin
                r_s1_voice <= w_sel_idx;
                r_s1_phase <= phase[w_sel_idx*PHASE_W +: c_PHASE_W];
                r_s1_grant <= w_sel_onehot;
            end
            // Upper half-cycle mirrors the offset-binary table about mid-scale.
            if (r_s1_state == c_ST_FULL) begin
                r_sample_voice <= r_s1_voice;
                r_sample       <= r_s1_phase[c_PHASE_W-1] ? ~table_data : table_data;
            end
        end
    end

    assign sample_voice = r_sample_voice;
    assign sample       = r_sample;

endmodule
`default_nettype wire

// File: tb/tb_sine_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sine_voice_scheduler
// Brief    : Directed self-checking bench with a quarter-wave sine table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sine_voice_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] phase;
    logic [3:0]  grant;
    logic [5:0]  table_phase;
    logic [15:0] table_data;
    logic        sample_valid;
    logic [1:0]  sample_voice;
    logic [15:0] sample;

    logic [15:0] rom [64];
    logic [15:0] exp_s [4];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign table_data = rom[table_phase];

    sine_voice_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .phase        (phase),
        .grant        (grant),
        .table_phase  (table_phase),
        .table_data   (table_data),
        .sample_valid (sample_valid),
        .sample_voice (sample_voice),
        .sample       (sample)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic single(input int v, input logic [7:0] ph, input logic [5:0] tp,
                          input logic [15:0] smp);
        req = 4'(1 << v);
        phase[v*8 +: 8] = ph;
        step();
        check("single_grant", 32'(grant), 32'(1 << v));
        check("single_tphase", 32'(table_phase), 32'(tp));
        check("single_valid_n1", 32'(sample_valid), 32'd0);
        req = 4'b0000;
        step();
        check("single_valid_n2", 32'(sample_valid), 32'd1);
        check("single_voice", 32'(sample_voice), 32'(v));
        check("single_sample", 32'(sample), 32'(smp));
        step();
        check("single_valid_n3", 32'(sample_valid), 32'd0);
        check("single_hold", 32'(sample), 32'(smp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 16'(32768 + $rtoi(32767.0 * $sin((i + 0.5) * 3.14159265358979 / 128.0) + 0.5));
        end
        exp_s[0] = 16'h8192;
        exp_s[1] = 16'hFFFD;
        exp_s[2] = 16'h7E6D;
        exp_s[3] = 16'h0016;

        // Reset with all requests high: nothing may be selected.
        reset = 1'b1;
        req   = 4'hF;
        phase = 32'h0;
        step();
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_voice", 32'(sample_voice), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_tphase", 32'(table_phase), 32'd0);
        reset = 1'b0;
        req   = 4'h0;
        step();
        check("post_rst_grant", 32'(grant), 32'd0);
        check("post_rst_valid", 32'(sample_valid), 32'd0);

        single(0, 8'h00, 6'h00, 16'h8192);
        single(0, 8'h40, 6'h3F, 16'hFFFD);
        single(2, 8'h80, 6'h00, 16'h7E6D);
        single(2, 8'hC1, 6'h3E, 16'h0016);

        // Voice 2 last granted: voice 3 wins over voice 1.
        phase = 32'h0;
        req = 4'b1010;
        step();
        check("rr_first_grant", 32'(grant), 32'b1000);
        req = 4'b0010;
        step();
        check("rr_second_grant", 32'(grant), 32'b0010);
        check("rr_valid3", 32'(sample_valid), 32'd1);
        check("rr_voice3", 32'(sample_voice), 32'd3);
        req = 4'b0000;
        step();
        check("rr_no_dup", 32'(grant), 32'd0);
        check("rr_voice1", 32'(sample_voice), 32'd1);
        step();
        check("rr_idle_grant", 32'(grant), 32'd0);
        check("rr_idle_valid", 32'(sample_valid), 32'd0);

        // Held single request: grant every other cycle.
        req = 4'b0001;
        step();
        check("hold_g1", 32'(grant), 32'b0001);
        check("hold_v1", 32'(sample_valid), 32'd0);
        step();
        check("hold_g2", 32'(grant), 32'b0000);
        check("hold_v2", 32'(sample_valid), 32'd1);
        step();
        check("hold_g3", 32'(grant), 32'b0001);
        check("hold_v3", 32'(sample_valid), 32'd0);
        req = 4'b0000;
        step();
        check("hold_g4", 32'(grant), 32'b0000);
        check("hold_v4", 32'(sample_valid), 32'd1);
        step();
        check("hold_g5", 32'(grant), 32'b0000);
        check("hold_v5", 32'(sample_valid), 32'd0);

        // All four voices held from reset.
        reset = 1'b1;
        req   = 4'h0;
        step();
        req   = 4'hF;
        phase = 32'hC1804000;
        step();
        check("all_rst_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("all_grant", 32'(grant), 32'(1 << (i % 4)));
            if (i >= 1) begin
                check("all_valid", 32'(sample_valid), 32'd1);
                check("all_voice", 32'(sample_voice), 32'((i - 1) % 4));
                check("all_sample", 32'(sample), 32'(exp_s[(i - 1) % 4]));
            end else begin
                check("all_valid0", 32'(sample_valid), 32'd0);
            end
        end
        req = 4'h0;
        repeat (3) step();

        // Reset right after a grant drops the in-flight sample.
        req = 4'b0010;
        step();
        check("mid_grant", 32'(grant), 32'b0010);
        reset = 1'b1;
        req   = 4'b0000;
        step();
        check("mid_valid", 32'(sample_valid), 32'd0);
        check("mid_grant0", 32'(grant), 32'd0);
        check("mid_sample", 32'(sample), 32'd0);
        check("mid_voice", 32'(sample_voice), 32'd0);
        check("mid_tphase", 32'(table_phase), 32'd0);
        reset = 1'b0;
        step();
        check("mid_after1", 32'(sample_valid), 32'd0);
        step();
        check("mid_after2", 32'(sample_valid), 32'd0);
        req = 4'b1011;
        step();
        check("mid_favour0", 32'(grant), 32'b0001);
        req = 4'b0000;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
